// File: rtl/axis_accumulator_v2.sv
// Purpose: AXI-Stream accumulator. It returns one sum per packet (mode 0) or one
//          prefix sum per beat (mode 1) through a first-word-fall-through FIFO.
// Latency: a beat accepted at edge k has its result at the FIFO head after edge k.
// Backpressure: s_axis_ready is low while the FIFO is full. The outputs hold steady while m_axis_ready is low.
// Ports: axi_clk/axi_rst (async, active-high), cfg_mode, s_axis_* (slave stream),
//        m_axis_* (master stream, user = packet overflow), fifo_level, o_intr.

// Small FWFT FIFO. The head entry is visible whenever rd_vld is high.
// The write side must not push while the FIFO is full.
module axis_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_fire;

  assign rd_vld  = (count != '0);
  assign rd_fire = rd_vld & rd_rdy;
  // The head reads as zero when the FIFO is empty, so the outputs are clean after reset.
  assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_vld, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end
endmodule

module axis_accumulator_v2 #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 40,
  parameter int FIFO_DEPTH = 16,
  parameter int SIGNED     = 0,
  parameter int SATURATE   = 0
) (
  input  logic                          axi_clk,
  input  logic                          axi_rst,
  input  logic                          cfg_mode,
  input  logic [DATA_W-1:0]             s_axis_data,
  input  logic                          s_axis_valid,
  input  logic                          s_axis_last,
  output logic                          s_axis_ready,
  output logic [ACC_W-1:0]              m_axis_data,
  output logic                          m_axis_valid,
  output logic                          m_axis_last,
  output logic                          m_axis_user,
  input  logic                          m_axis_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          o_intr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    DEPTH_L = CW'(FIFO_DEPTH);
  localparam logic [ACC_W-1:0] U_MAX   = '1;
  localparam logic [ACC_W-1:0] S_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic             mode_q;
  logic             pkt_ovf;
  logic             rdy_en;

  logic             accept;
  logic             eff_mode;
  logic             wr_en;
  logic             ovf;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sat_val;
  logic [ACC_W-1:0] result;
  logic [ACC_W:0]   sum;
  logic [ACC_W+1:0] wr_entry;
  logic [ACC_W+1:0] rd_entry;

  // Widen the beat to the accumulator width. The beat is sign-extended when SIGNED is set.
  if (ACC_W > DATA_W) begin : g_ext
    assign ext = (SIGNED != 0) ? {{(ACC_W-DATA_W){s_axis_data[DATA_W-1]}}, s_axis_data}
                               : {{(ACC_W-DATA_W){1'b0}}, s_axis_data};
  end else begin : g_noext
    assign ext = s_axis_data;
  end

  always_comb begin
    base = (state == ST_ACTIVE) ? acc : '0;
    sum  = {1'b0, base} + {1'b0, ext};
    if (SIGNED != 0) begin
      // Signed overflow happens when both operands have the same sign and the result sign differs.
      // The sign of base gives the clamp direction.
      ovf     = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
      sat_val = base[ACC_W-1] ? S_MIN : S_MAX;
    end else begin
      ovf     = sum[ACC_W];
      sat_val = U_MAX;
    end
    result = (ovf && (SATURATE != 0)) ? sat_val : sum[ACC_W-1:0];
  end

  // Ready comes only from registers. A read in the same cycle does not open a full FIFO.
  // rdy_en holds ready low until the first edge after reset is released.
  assign s_axis_ready = rdy_en & ~axi_rst & (fifo_level < DEPTH_L);
  assign accept       = s_axis_valid & s_axis_ready;

  // The first beat of a packet uses the live cfg_mode. Later beats use the latched mode.
  assign eff_mode = (state == ST_IDLE) ? cfg_mode : mode_q;
  assign wr_en    = accept & (eff_mode | s_axis_last);
  assign wr_entry = {pkt_ovf | ovf, s_axis_last, result};

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mode_q  <= 1'b0;
      pkt_ovf <= 1'b0;
      rdy_en  <= 1'b0;
      o_intr  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      o_intr <= accept & s_axis_last;
      if (accept) begin
        if (s_axis_last) begin
          state   <= ST_IDLE;
          acc     <= '0;
          pkt_ovf <= 1'b0;
        end else begin
          if (state == ST_IDLE) mode_q <= cfg_mode;
          state   <= ST_ACTIVE;
          acc     <= result;
          pkt_ovf <= pkt_ovf | ovf;
        end
      end
    end
  end

  axis_fifo_fwft #(
    .WIDTH (ACC_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (axi_clk),
    .rst    (axi_rst),
    .wr_vld (wr_en),
    .wr_dat (wr_entry),
    .rd_rdy (m_axis_ready),
    .rd_vld (m_axis_valid),
    .rd_dat (rd_entry),
    .count  (fifo_level)
  );

  assign {m_axis_user, m_axis_last, m_axis_data} = rd_entry;
endmodule
